// File: rtl/seg7_pkg.sv
// Shared types and the active-low abcdefg hex glyph table for the seg7 display driver.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Index = nibble value; bit 6 = segment a, bit 0 = segment g, 0 = lit.
    localparam seg_t HEX_SEG [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic seg_t hex2seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg7_hexdec.sv
// Combinational nibble-to-segment decoder, one instance on the muxed digit nibble.
module seg7_hexdec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex2seg(nibble_i);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed hex display driver for 1..8 common-anode digits with per-slot anti-ghost blank.
// Optional leading-zero blanking is built when SEG7_SCAN_LZB_EN is defined.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 1024,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DIGITS*4-1:0]   din,
    input  logic [DIGITS-1:0]     dp,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS*4-1:0] sh_din_q;
    logic [DIGITS-1:0]   sh_dp_q;
    logic [6:0]          seg_q, seg_d;
    logic                dp_n_q, dp_n_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;

    logic                slot_end;
    logic [3:0]          nib;
    logic                dp_sel;
    logic [6:0]          hex_seg;
    logic                lz_blank;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        slot_end = (pcnt_q == PCNT_MAX);
        pcnt_d   = slot_end ? '0 : pcnt_q + 1'b1;
        idx_d    = idx_q;
        frame_d  = 1'b0;
        if (slot_end) begin
            if (idx_q == IDX_MAX) begin
                idx_d   = '0;
                frame_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        nib    = 4'h0;
        dp_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib    = sh_din_q[i*4 +: 4];
                dp_sel = sh_dp_q[i];
            end
        end
    end

    seg7_hexdec u_hexdec (
        .nibble_i (nib),
        .seg_o    (hex_seg)
    );

`ifdef SEG7_SCAN_LZB_EN
    logic [DIGITS-1:0] lz_mask;
    logic              zeros_above;

    // A digit blanks only while it and every more significant nibble are zero; digit 0 always shows.
    always_comb begin
        lz_mask     = '0;
        zeros_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zeros_above = zeros_above && (sh_din_q[i*4 +: 4] == 4'h0);
            lz_mask[i]  = zeros_above && !sh_dp_q[i];
        end
        lz_blank = |(lz_mask & (DIGITS'(1) << idx_q));
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        an_d   = '1;
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        if (pcnt_q >= BLANK_END) begin
            an_d   = ~(DIGITS'(1) << idx_q);
            seg_d  = lz_blank ? SEG_BLANK : hex_seg;
            dp_n_d = ~dp_sel;
        end
    end

    // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
    // The shadow is reset too, so the first frame after reset shows zeros rather than garbage.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q   <= '0;
            idx_q    <= '0;
            sh_din_q <= '0;
            sh_dp_q  <= '0;
            seg_q    <= SEG_BLANK;
            dp_n_q   <= 1'b1;
            an_q     <= '1;
            frame_q  <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            if (load) begin
                sh_din_q <= din;
                sh_dp_q  <= dp;
            end
            seg_q   <= seg_d;
            dp_n_q  <= dp_n_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp_n  = dp_n_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (DIGITS=4, CLK_DIV=4, BLANK_CYC=1); stimulus queues expected lit-digit
// outputs, a negedge monitor pops them whenever an anode is low.
module tb_seg7_scan;

    localparam int DIG   = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;

    localparam logic [6:0] HEX_TBL [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame;

    seg7_scan #(
        .DIGITS    (DIG),
        .CLK_DIV   (DIV),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .din   (din),
        .dp    (dp),
        .seg   (seg),
        .dp_n  (dp_n),
        .an    (an),
        .frame (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] sb [$];
    int          n;
    logic [15:0] m_din;
    logic [3:0]  m_dp;
    int          frame_cnt = 0;
    int          gap = 0;
    bit          have_frame = 1'b0;
    logic [6:0]  seen_seg [4];
    logic        seen_dp [4];
    bit          seen_v [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input logic [3:0] p, input int i);
        logic [6:0] s;
        s = HEX_TBL[d[i*4 +: 4]];
`ifdef SEG7_SCAN_LZB_EN
        if (i > 0 && !p[i] && ((d >> (4 * i)) == 16'h0)) s = 7'h7F;
`endif
        return s;
    endfunction

    // Drive one cycle; the expected output two edges later (state after the coming edge) is queued.
    task automatic tick(input logic ld, input logic [15:0] d, input logic [3:0] p, input bit push = 1'b1);
        int         np;
        int         ni;
        logic [3:0] a;
        load = ld;
        din  = d;
        dp   = p;
        if (ld) begin
            m_din = d;
            m_dp  = p;
        end
        if (push) begin
            np = (n + 1) % DIV;
            ni = ((n + 1) / DIV) % DIG;
            if (np >= BLANK) begin
                a = ~(4'b0001 << ni);
                sb.push_back({a, exp_seg(m_din, m_dp, ni), ~m_dp[ni]});
            end
        end
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) begin
            seen_v[i]   = 1'b0;
            seen_seg[i] = 'x;
            seen_dp[i]  = 1'bx;
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] e;
        if (reset) begin
            gap        = 0;
            have_frame = 1'b0;
        end else begin
            if (an == 4'hF) begin
                check("blank_slot", {seg, dp_n}, {7'h7F, 1'b1});
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got an=%b seg=%h with nothing queued (t=%0t)", an, seg, $time);
            end else begin
                e = sb.pop_front();
                check("scan", {an, seg, dp_n}, e);
            end
            for (int i = 0; i < 4; i++) begin
                if (!an[i] && !seen_v[i]) begin
                    seen_v[i]   = 1'b1;
                    seen_seg[i] = seg;
                    seen_dp[i]  = dp_n;
                end
            end
            gap++;
            if (frame) begin
                frame_cnt++;
                if (have_frame) check("frame_period", gap, DIG * DIV);
                have_frame = 1'b1;
                gap        = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         f0;
        int         nd;
        logic [15:0] d;
        reset = 1'b1;
        load  = 1'b0;
        din   = '0;
        dp    = '0;
        n     = 0;
        m_din = '0;
        m_dp  = '0;
        clear_seen();
        repeat (3) @(posedge clk);
        #1;
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp_n", dp_n, 1'b1);
        check("reset_frame", frame, 1'b0);
        reset = 1'b0;
        n     = 0;

        // Reset scan with an all-zero word; two frames must be seen in 33 edges.
        f0 = frame_cnt;
        tick(1'b1, 16'h0000, 4'h0);
        repeat (32) tick(1'b0, 16'h0, 4'h0);
        check("frame_count", frame_cnt - f0, 2);

        // Mixed hex word with one decimal point.
        tick(1'b1, 16'h1A3F, 4'b0100);
        tick(1'b0, 16'h0, 4'h0);
        clear_seen();
        repeat (16) tick(1'b0, 16'h0, 4'h0);
        check("w1a3f_dig0", seen_seg[0], 7'h38);
        check("w1a3f_dig1", seen_seg[1], 7'h06);
        check("w1a3f_dig2", seen_seg[2], 7'h08);
        check("w1a3f_dp2", seen_dp[2], 1'b0);
        check("w1a3f_dp0", seen_dp[0], 1'b1);
        check("w1a3f_dig3", seen_seg[3], 7'h4F);

        // Load landing on the slot boundary: the next digit must come from the new word only.
        tick(1'b1, 16'h0000, 4'h0);
        while (n % DIV != DIV - 1) tick(1'b0, 16'h0, 4'h0);
        nd = ((n + 1) / DIV) % DIG;
        clear_seen();
        tick(1'b1, 16'h5555, 4'h0);
        repeat (4) tick(1'b0, 16'h0, 4'h0);
        check("boundary_seg", seen_seg[nd], 7'h24);

        // Leading zeros.
        tick(1'b1, 16'h0042, 4'h0);
        tick(1'b0, 16'h0, 4'h0);
        clear_seen();
        repeat (16) tick(1'b0, 16'h0, 4'h0);
`ifdef SEG7_SCAN_LZB_EN
        check("lz_dig3", seen_seg[3], 7'h7F);
        check("lz_dig2", seen_seg[2], 7'h7F);
`else
        check("lz_dig3", seen_seg[3], 7'h01);
        check("lz_dig2", seen_seg[2], 7'h01);
`endif
        check("lz_dig1", seen_seg[1], 7'h4C);
        check("lz_dig0", seen_seg[0], 7'h12);

        // Reset in the middle of digit 2's lit window.
        while (n % (DIG * DIV) != 10) tick(1'b0, 16'h0, 4'h0);
        check("pre_reset_an", an, 4'b1011);
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("midreset_an", an, 4'hF);
        check("midreset_seg", seg, 7'h7F);
        check("midreset_dp_n", dp_n, 1'b1);
        check("midreset_frame", frame, 1'b0);
        reset = 1'b0;
        n     = 0;
        m_din = '0;
        m_dp  = '0;
        tick(1'b0, 16'h0, 4'h0);
        check("post_reset_blank_an", an, 4'hF);
        tick(1'b0, 16'h0, 4'h0);
        check("post_reset_first_an", an, 4'b1110);

        // Transparent mode: load held high with a new word every cycle.
        for (int k = 0; k < 24; k++) begin
            d = 16'h1357 + 16'(k) * 16'h0F1D;
            tick(1'b1, d, 4'(k));
        end

        tick(1'b0, 16'h0, 4'h0, 1'b0);
        tick(1'b0, 16'h0, 4'h0, 1'b0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
